// File: rtl/clk_div_ctrl.sv
// Configuration and run controller for the clock divider: computes the divider
// terminal count (sys/req)*2 with a restoring divider and applies it on tick boundaries.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | divider disabled, waiting for a configuration or start
// CALC       | restoring division, one quotient bit per cycle
// WAIT_EDGE  | valid result while running, waiting for a divider tick
// LOAD       | new value (or reject) presented for one cycle
// RUN        | divider enabled, counting ticks
// STOP       | divider still enabled until the next tick, then IDLE

module clk_div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_sys_clk,
    input  logic [WIDTH-1:0] cfg_req_clk,
    output logic             cfg_err,
    input  logic             start,
    input  logic             stop,
    output logic             div_en,
    output logic [WIDTH-1:0] div_value,
    output logic             div_load,
    input  logic             div_tick,
    output logic             busy,
    output logic [CNT_W-1:0] tick_cnt
);

    localparam int BIT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_WAIT_EDGE,
        ST_LOAD,
        ST_RUN,
        ST_STOP
    } state_t;

    state_t           state_q, state_d;
    logic             ret_run_q, ret_run_d;
    logic             stop_pend_q, stop_pend_d;
    logic             cfg_loaded_q, cfg_loaded_d;
    logic             div_en_q, div_en_d;
    logic [WIDTH-1:0] div_value_q, div_value_d;
    logic             div_load_q, div_load_d;
    logic             cfg_err_q, cfg_err_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_diff;
    logic             q_bit;
    logic [WIDTH-1:0] quo_next;
    logic             reject;

    // One restoring step: the quotient register shifts the dividend out as it
    // shifts quotient bits in, so after WIDTH steps it holds the full quotient.
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        q_bit     = (rem_shift >= {1'b0, dsr_q});
        rem_diff  = rem_shift[WIDTH-1:0] - dsr_q;
        quo_next  = {quo_q[WIDTH-2:0], q_bit};
        reject    = (dsr_q == '0) || (quo_next == '0) || quo_next[WIDTH-1];
    end

    always_comb begin
        state_d      = state_q;
        ret_run_d    = ret_run_q;
        stop_pend_d  = stop_pend_q;
        cfg_loaded_d = cfg_loaded_q;
        div_en_d     = div_en_q;
        div_value_d  = div_value_q;
        div_load_d   = 1'b0;
        cfg_err_d    = 1'b0;
        tick_cnt_d   = tick_cnt_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        dsr_d        = dsr_q;
        bit_cnt_d    = bit_cnt_q;

        if (div_en_q && div_tick) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    quo_d     = cfg_sys_clk;
                    dsr_d     = cfg_req_clk;
                    rem_d     = '0;
                    bit_cnt_d = BIT_W'(WIDTH - 1);
                    ret_run_d = 1'b0;
                    state_d   = ST_CALC;
                end else if (start && cfg_loaded_q) begin
                    div_en_d = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_STOP;
                end else if (cfg_valid) begin
                    quo_d     = cfg_sys_clk;
                    dsr_d     = cfg_req_clk;
                    rem_d     = '0;
                    bit_cnt_d = BIT_W'(WIDTH - 1);
                    ret_run_d = 1'b1;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                if (stop && ret_run_q) begin
                    stop_pend_d = 1'b1;
                end
                rem_d     = q_bit ? rem_diff : rem_shift[WIDTH-1:0];
                quo_d     = quo_next;
                bit_cnt_d = bit_cnt_q - 1'b1;
                if (bit_cnt_q == '0) begin
                    // Rejects still pass through LOAD so both outcomes share timing.
                    if (reject) begin
                        cfg_err_d = 1'b1;
                        state_d   = ST_LOAD;
                    end else if (ret_run_q) begin
                        state_d = ST_WAIT_EDGE;
                    end else begin
                        div_value_d  = {quo_next[WIDTH-2:0], 1'b0};
                        div_load_d   = 1'b1;
                        cfg_loaded_d = 1'b1;
                        tick_cnt_d   = '0;
                        state_d      = ST_LOAD;
                    end
                end
            end
            ST_WAIT_EDGE: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (div_tick) begin
                    div_value_d  = {quo_q[WIDTH-2:0], 1'b0};
                    div_load_d   = 1'b1;
                    cfg_loaded_d = 1'b1;
                    tick_cnt_d   = '0;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                stop_pend_d = 1'b0;
                if (ret_run_q) begin
                    state_d = (stop_pend_q || stop) ? ST_STOP : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STOP: begin
                if (div_tick) begin
                    div_en_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_CALC) || (state_d == ST_WAIT_EDGE) ||
                 (state_d == ST_LOAD) || (state_d == ST_STOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ret_run_q    <= 1'b0;
            stop_pend_q  <= 1'b0;
            cfg_loaded_q <= 1'b0;
            div_en_q     <= 1'b0;
            div_value_q  <= '0;
            div_load_q   <= 1'b0;
            cfg_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            tick_cnt_q   <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dsr_q        <= '0;
            bit_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ret_run_q    <= ret_run_d;
            stop_pend_q  <= stop_pend_d;
            cfg_loaded_q <= cfg_loaded_d;
            div_en_q     <= div_en_d;
            div_value_q  <= div_value_d;
            div_load_q   <= div_load_d;
            cfg_err_q    <= cfg_err_d;
            busy_q       <= busy_d;
            tick_cnt_q   <= tick_cnt_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            dsr_q        <= dsr_d;
            bit_cnt_q    <= bit_cnt_d;
        end
    end

    assign cfg_ready = (state_q == ST_IDLE) || ((state_q == ST_RUN) && !stop);
    assign cfg_err   = cfg_err_q;
    assign div_en    = div_en_q;
    assign div_value = div_value_q;
    assign div_load  = div_load_q;
    assign busy      = busy_q;
    assign tick_cnt  = tick_cnt_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: scenario tasks with randomized operands,
// expectations taken from a transaction-level model of the controller.

module tb_clk_div_ctrl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_sys_clk;
    logic [WIDTH-1:0] cfg_req_clk;
    logic             cfg_err;
    logic             start;
    logic             stop;
    logic             div_en;
    logic [WIDTH-1:0] div_value;
    logic             div_load;
    logic             div_tick;
    logic             busy;
    logic [CNT_W-1:0] tick_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // transaction-level model state
    logic [WIDTH-1:0] exp_val;
    logic             exp_loaded;
    int               exp_cnt;

    always #5 clk = ~clk;

    clk_div_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_sys_clk(cfg_sys_clk),
        .cfg_req_clk(cfg_req_clk),
        .cfg_err    (cfg_err),
        .start      (start),
        .stop       (stop),
        .div_en     (div_en),
        .div_value  (div_value),
        .div_load   (div_load),
        .div_tick   (div_tick),
        .busy       (busy),
        .tick_cnt   (tick_cnt)
    );

    function automatic logic model_reject(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] r);
        longint unsigned q;
        if (r == 0) return 1'b1;
        q = longint'(s) / longint'(r);
        return (q == 0) || (q >= 64'h8000_0000);
    endfunction

    function automatic logic [WIDTH-1:0] model_value(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] r);
        longint unsigned q;
        q = longint'(s) / longint'(r);
        return WIDTH'(q * 2);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_val    = '0;
        exp_loaded = 1'b0;
        exp_cnt    = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_chk++;
        if ({div_en, div_load, cfg_err, busy, cfg_ready, tick_cnt, div_value} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_vals: en=%b ld=%b err=%b busy=%b rdy=%b cnt=%0d val=%h, want 0 0 0 0 1 0 0",
                     div_en, div_load, cfg_err, busy, cfg_ready, tick_cnt, div_value);
        end
        rst = 1'b0;
        model_reset();
        step();
        n_chk++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b want 1", cfg_ready);
        end
    endtask

    task automatic test_start_unconfigured();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        n_chk++;
        if (div_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_unconfigured: div_en=%b busy=%b want 0 0", div_en, busy);
        end
    endtask

    // Configuration from IDLE; optionally with start in the handshake cycle.
    task automatic test_cfg_idle(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] r, input bit with_start);
        logic rej;
        rej = model_reject(s, r);
        cfg_sys_clk = s;
        cfg_req_clk = r;
        cfg_valid   = 1'b1;
        start       = with_start;
        #1;
        n_chk++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready: got %b want 1", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        start     = 1'b0;
        n_chk++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_calc_busy: busy=%b rdy=%b want 1 0", busy, cfg_ready);
        end
        repeat (WIDTH - 1) step();
        n_chk++;
        if (div_load !== 1'b0 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_early_result: ld=%b err=%b want 0 0", div_load, cfg_err);
        end
        step();
        if (rej) begin
            n_chk++;
            if (cfg_err !== 1'b1 || div_load !== 1'b0 || div_value !== exp_val) begin
                n_fail++;
                $display("FAIL idle_reject s=%h r=%h: err=%b ld=%b val=%h want 1 0 %h",
                         s, r, cfg_err, div_load, div_value, exp_val);
            end
        end else begin
            exp_val    = model_value(s, r);
            exp_loaded = 1'b1;
            exp_cnt    = 0;
            n_chk++;
            if (div_load !== 1'b1 || div_value !== exp_val || cfg_err !== 1'b0 || tick_cnt !== 16'd0) begin
                n_fail++;
                $display("FAIL idle_load s=%h r=%h: ld=%b val=%h err=%b cnt=%0d want 1 %h 0 0",
                         s, r, div_load, div_value, cfg_err, tick_cnt, exp_val);
            end
        end
        step();
        n_chk++;
        if (cfg_ready !== 1'b1 || div_load !== 1'b0 || cfg_err !== 1'b0 || busy !== 1'b0 || div_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_return: rdy=%b ld=%b err=%b busy=%b en=%b want 1 0 0 0 0",
                     cfg_ready, div_load, cfg_err, busy, div_en);
        end
    endtask

    task automatic test_run_start();
        start = 1'b1;
        step();
        start = 1'b0;
        n_chk++;
        if (div_en !== exp_loaded || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL run_start: en=%b busy=%b want %b 0", div_en, busy, exp_loaded);
        end
    endtask

    task automatic test_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            div_tick = 1'b1;
            step();
            exp_cnt++;
        end
        div_tick = 1'b0;
        n_chk++;
        if (tick_cnt !== CNT_W'(exp_cnt)) begin
            n_fail++;
            $display("FAIL tick_count n=%0d: got %0d want %0d", n, tick_cnt, CNT_W'(exp_cnt));
        end
    endtask

    // Reconfiguration while running; optional stop pulse mid-CALC.
    task automatic test_cfg_run(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] r,
                                input int wait_cyc, input bit stop_mid);
        logic rej;
        rej = model_reject(s, r);
        cfg_sys_clk = s;
        cfg_req_clk = r;
        cfg_valid   = 1'b1;
        #1;
        n_chk++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL run_ready: got %b want 1", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        for (int i = 1; i <= WIDTH; i++) begin
            div_tick = (i == WIDTH) ? 1'b1 : 1'($urandom_range(0, 1));
            stop     = stop_mid && (i == 5);
            if (div_tick) exp_cnt++;
            step();
        end
        div_tick = 1'b0;
        stop     = 1'b0;
        if (rej) begin
            n_chk++;
            if (cfg_err !== 1'b1 || div_value !== exp_val || div_load !== 1'b0 || tick_cnt !== CNT_W'(exp_cnt)) begin
                n_fail++;
                $display("FAIL run_reject s=%h r=%h: err=%b val=%h ld=%b cnt=%0d want 1 %h 0 %0d",
                         s, r, cfg_err, div_value, div_load, tick_cnt, exp_val, CNT_W'(exp_cnt));
            end
        end else begin
            n_chk++;
            if (div_value !== exp_val || div_load !== 1'b0 || busy !== 1'b1 || div_en !== 1'b1) begin
                n_fail++;
                $display("FAIL wait_edge_hold: val=%h ld=%b busy=%b en=%b want %h 0 1 1",
                         div_value, div_load, busy, div_en, exp_val);
            end
            repeat (wait_cyc) step();
            div_tick = 1'b1;
            step();
            div_tick = 1'b0;
            exp_val  = model_value(s, r);
            exp_cnt  = 0;
            n_chk++;
            if (div_value !== exp_val || div_load !== 1'b1 || tick_cnt !== 16'd0) begin
                n_fail++;
                $display("FAIL run_load s=%h r=%h: val=%h ld=%b cnt=%0d want %h 1 0",
                         s, r, div_value, div_load, tick_cnt, exp_val);
            end
        end
        step();
        n_chk++;
        if (stop_mid) begin
            if (busy !== 1'b1 || div_en !== 1'b1 || cfg_ready !== 1'b0 || div_load !== 1'b0 || cfg_err !== 1'b0) begin
                n_fail++;
                $display("FAIL run_to_stop: busy=%b en=%b rdy=%b ld=%b err=%b want 1 1 0 0 0",
                         busy, div_en, cfg_ready, div_load, cfg_err);
            end
        end else begin
            if (busy !== 1'b0 || div_en !== 1'b1 || cfg_ready !== 1'b1 || div_load !== 1'b0 || cfg_err !== 1'b0) begin
                n_fail++;
                $display("FAIL run_return: busy=%b en=%b rdy=%b ld=%b err=%b want 0 1 1 0 0",
                         busy, div_en, cfg_ready, div_load, cfg_err);
            end
        end
    endtask

    // Already in STOP: enable must hold until a tick, then drop.
    task automatic test_finish_stop(input int idle_cyc);
        repeat (idle_cyc) step();
        n_chk++;
        if (div_en !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_hold: en=%b busy=%b want 1 1", div_en, busy);
        end
        div_tick = 1'b1;
        step();
        div_tick = 1'b0;
        exp_cnt++;
        n_chk++;
        if (div_en !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || tick_cnt !== CNT_W'(exp_cnt)) begin
            n_fail++;
            $display("FAIL stop_done: en=%b busy=%b rdy=%b cnt=%0d want 0 0 1 %0d",
                     div_en, busy, cfg_ready, tick_cnt, CNT_W'(exp_cnt));
        end
    endtask

    task automatic test_stop_with_cfg();
        bit seen;
        stop        = 1'b1;
        cfg_valid   = 1'b1;
        cfg_sys_clk = 32'd1000;
        cfg_req_clk = 32'd1;
        #1;
        n_chk++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_blocks_ready: got %b want 0", cfg_ready);
        end
        step();
        stop      = 1'b0;
        cfg_valid = 1'b0;
        test_finish_stop(3);
        seen = 1'b0;
        repeat (40) begin
            step();
            if (div_load || cfg_err || busy) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0 || div_value !== exp_val) begin
            n_fail++;
            $display("FAIL stop_cfg_dropped: activity=%b val=%h want 0 %h", seen, div_value, exp_val);
        end
    endtask

    task automatic test_rst_mid_calc();
        bit seen;
        cfg_sys_clk = 32'd300;
        cfg_req_clk = 32'd3;
        cfg_valid   = 1'b1;
        step();
        cfg_valid = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        n_chk++;
        if ({div_en, div_load, cfg_err, busy, cfg_ready, tick_cnt, div_value} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_calc: en=%b ld=%b err=%b busy=%b rdy=%b cnt=%0d val=%h",
                     div_en, div_load, cfg_err, busy, cfg_ready, tick_cnt, div_value);
        end
        seen = 1'b0;
        repeat (30) begin
            step();
            if (div_load || cfg_err || busy) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_discard: activity=%b want 0", seen);
        end
    endtask

    task automatic test_rst_mid_run();
        test_cfg_idle(32'd48_000_000, 32'd1_000_000, 1'b0);
        test_run_start();
        test_ticks(7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        n_chk++;
        if ({div_en, div_load, cfg_err, busy, cfg_ready, tick_cnt, div_value} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_run: en=%b ld=%b err=%b busy=%b rdy=%b cnt=%0d val=%h",
                     div_en, div_load, cfg_err, busy, cfg_ready, tick_cnt, div_value);
        end
        test_start_unconfigured();
    endtask

    task automatic test_wrap();
        test_cfg_idle(32'd1000, 32'd10, 1'b0);
        test_run_start();
        test_ticks(65535);
        test_ticks(1);
    endtask

    task automatic test_random_idle(input int n);
        logic [WIDTH-1:0] s, r;
        for (int i = 0; i < n; i++) begin
            s = $urandom;
            case ($urandom_range(0, 3))
                0: r = 32'($urandom_range(1, 65535));
                1: r = s + 32'($urandom_range(1, 100));
                2: r = 32'($urandom_range(1, 2));
                default: r = s >> $urandom_range(1, 20);
            endcase
            test_cfg_idle(s, r, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_random_run(input int n);
        logic [WIDTH-1:0] s, r;
        for (int i = 0; i < n; i++) begin
            s = 32'($urandom_range(1000, 200_000_000));
            r = (i == 1) ? s + 32'd1 : 32'($urandom_range(1, 100_000));
            test_cfg_run(s, r, $urandom_range(0, 4), 1'b0);
        end
    endtask

    initial begin
        rst         = 1'b1;
        cfg_valid   = 1'b0;
        cfg_sys_clk = '0;
        cfg_req_clk = '0;
        start       = 1'b0;
        stop        = 1'b0;
        div_tick    = 1'b0;
        model_reset();

        test_reset();
        test_start_unconfigured();
        test_cfg_idle(32'd100, 32'd10, 1'b0);
        test_run_start();
        test_ticks(5);
        test_cfg_run(32'd100, 32'd25, 2, 1'b0);
        test_cfg_run(32'd100, 32'd0, 0, 1'b0);
        test_cfg_run(32'd5, 32'd10, 0, 1'b0);
        test_cfg_run(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        test_cfg_run(32'hFFFF_FFFF, 32'd2, 0, 1'b0);
        test_random_run(3);
        test_ticks(3);
        test_stop_with_cfg();
        test_cfg_idle(32'd100, 32'd0, 1'b0);
        test_cfg_idle(32'd5, 32'd10, 1'b0);
        test_cfg_idle(32'hFFFF_FFFF, 32'd1, 1'b0);
        test_cfg_idle(32'd777, 32'd777, 1'b1);
        test_random_idle(5);
        test_cfg_idle(32'd640, 32'd8, 1'b0);
        test_run_start();
        test_ticks(4);
        test_cfg_run(32'd900, 32'd30, 1, 1'b1);
        test_finish_stop(2);
        test_rst_mid_calc();
        test_rst_mid_run();
        test_wrap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Configuration and run controller for the team's clock divider. It accepts a frequency request as a (system clock, required clock) pair over a valid/ready handshake and computes the divider terminal count with a sequential divider. It then loads the count into the divider and drives the divider's enable. Reconfiguration while running is applied only on a divider tick boundary, so the divided output never produces a runt cycle.

## Interface
- WIDTH, 32: width of the frequency operands and of the divider value.
- CNT_W, 16: width of the tick counter.

- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration request valid.
- cfg_ready  out  1  controller can accept a configuration this cycle.
- cfg_sys_clk  in  WIDTH  system clock frequency (Hz), sampled on handshake.
- cfg_req_clk  in  WIDTH  required clock frequency (Hz), sampled on handshake.
- cfg_err  out  1  one-cycle pulse: the last request was rejected.
- start  in  1  request to enable the divider.
- stop  in  1  request to disable the divider gracefully.
- div_en  out  1  enable to the divider.
- div_value  out  WIDTH  divider terminal count, equal to (sys/req)*2.
- div_load  out  1  one-cycle pulse when div_value changes.
- div_tick  in  1  tick pulse from the divider.
- busy  out  1  high in CALC, WAIT_EDGE, LOAD, STOP.
- tick_cnt  out  CNT_W  number of div_tick pulses seen while div_en=1.

## Operation
- States: IDLE, CALC, WAIT_EDGE, LOAD, RUN, STOP. The controller also holds a flag `cfg_loaded` and a flag `ret_run`, which records whether CALC was entered from RUN.
- cfg_ready = (state==IDLE) | (state==RUN & !stop). Ready is combinational and is low in every other state.
- Handshake (cfg_valid & cfg_ready):
  - captures both operands;
  - sets ret_run = (state==RUN);
  - moves to CALC.
- CALC: restoring unsigned division sys/req, one quotient bit per cycle, exactly WIDTH cycles. The result is q<<1.
- A request is rejected when any of these holds: req==0, q==0 (req>sys), or q[WIDTH-1]==1 (the doubled value overflows).
  - On reject, cfg_err pulses and the controller returns to RUN if ret_run, otherwise to IDLE.
  - div_value, div_load and cfg_loaded are unchanged on reject.
- Valid result:
  - if ret_run, go to WAIT_EDGE;
  - otherwise go to LOAD.
- WAIT_EDGE: div_en stays 1; the controller waits for div_tick=1, then goes to LOAD.
- LOAD:
  - div_value <= result; div_load=1 for one cycle;
  - cfg_loaded <= 1; tick_cnt <= 0;
  - next state is RUN if ret_run, otherwise IDLE.
- IDLE:
  - start & cfg_loaded → RUN, with div_en=1 from the next cycle;
  - start with cfg_loaded=0 is ignored;
  - cfg_valid and start in the same cycle: the configuration is taken and start is ignored.
- RUN: stop → STOP. stop has priority over a same-cycle cfg_valid, which is not accepted.
- STOP: div_en stays 1 until div_tick=1. In that cycle the state goes to IDLE and div_en=0 from the next cycle.
- A stop arriving during CALC/WAIT_EDGE/LOAD with ret_run=1 is latched (stop_pend). The update completes, then the controller goes directly to STOP instead of RUN. stop in those states with ret_run=0 is ignored.
- tick_cnt increments on div_tick while div_en=1 and wraps from 2^CNT_W-1 to 0.
- start/stop outside the states listed above are ignored.

## Timing
- Reset values: state=IDLE, div_en=0, div_value=0, div_load=0, cfg_err=0, cfg_loaded=0, tick_cnt=0, busy=0, stop_pend=0. cfg_ready is therefore 1 the cycle after reset.
- Reset has priority in any state, including mid-CALC; a partial result is discarded.
- Handshake at cycle T: CALC occupies T+1..T+WIDTH.
  - Idle path: LOAD at T+WIDTH+1 (div_load=1, new div_value visible), IDLE at T+WIDTH+2.
  - Reject: cfg_err=1 at cycle T+WIDTH+1, previous state restored at T+WIDTH+2.
  - Run path: WAIT_EDGE from T+WIDTH+1. For a tick at cycle K, LOAD is at K+1.
- A div_tick in the same cycle the controller enters WAIT_EDGE is not counted as the edge; the controller waits for the next tick.
- All outputs except cfg_ready are registered.

## Test plan
- Reset, then cfg sys=100, req=10 at T → CALC for 32 cycles; div_load=1 and div_value=20 at T+33; cfg_ready=1 at T+34; div_en remains 0.
- Then start → div_en=1 next cycle. Drive 5 ticks → tick_cnt=5. Cfg sys=100, req=25 while running → div_value stays 20 until the first tick after CALC; div_value=8 in the following cycle; tick_cnt=0.
- Reject cases, from IDLE and from RUN:
  - req=0 → cfg_err pulse at T+33, div_value unchanged;
  - sys=5, req=10 → cfg_err;
  - sys=0xFFFF_FFFF, req=1 → cfg_err (overflow).
- stop in RUN with cfg_valid in the same cycle → cfg not accepted; div_en drops the cycle after the next div_tick; start before any config after reset → ignored, div_en=0.
- stop asserted during a run-path CALC → the update is applied at the next tick, then STOP; div_en falls after the following tick.
- Synchronous rst mid-CALC and mid-RUN → all outputs at reset values next cycle; drive 65 536 ticks with div_en=1 → tick_cnt wraps to 0.
